// File: rtl/csi2_pkt_ctrl.sv
// CSI-2 packet sequencer: decodes the ECC-checked header, forwards payload words,
// extracts the packet CRC and handshakes pkt_done_o back to the header decoder.
module csi2_pkt_ctrl #(
   parameter logic [15:0] MAX_WC       = 16'd8192,
   parameter logic [5:0]  SHORT_DT_MAX = 6'h0F,
   parameter int          CNT_W        = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   input  logic [31:0]      data_i,
   input  logic             error_i,
   input  logic             error_corrected_i,
   input  logic             eot_i,
   output logic             pkt_done_o,
   output logic             hdr_valid_o,
   output logic [1:0]       hdr_vc_o,
   output logic [5:0]       hdr_dt_o,
   output logic [15:0]      hdr_wc_o,
   output logic             short_pkt_o,
   output logic             pl_valid_o,
   output logic [31:0]      pl_data_o,
   output logic [3:0]       pl_strb_o,
   output logic             pl_last_o,
   output logic [15:0]      crc_o,
   output logic             crc_valid_o,
   output logic             wc_trunc_o,
   output logic [CNT_W-1:0] ecc_corr_cnt_o,
   output logic [CNT_W-1:0] ecc_err_cnt_o
);

   typedef enum logic [2:0] {IDLE, PAYLOAD, CRC, DONE, DROP} state_t;

   state_t state_q, state_d;

   logic [15:0] wc_q, wc_d;
   logic [16:0] p_q, p_d;
   logic [16:0] cnt_q, cnt_d;
   logic [7:0]  last_hi_q, last_hi_d;

   logic             pkt_done_d, hdr_valid_d, short_pkt_d, pl_valid_d, pl_last_d;
   logic             crc_valid_d, wc_trunc_d;
   logic [1:0]       hdr_vc_d;
   logic [5:0]       hdr_dt_d;
   logic [15:0]      hdr_wc_d, crc_d;
   logic [31:0]      pl_data_d;
   logic [3:0]       pl_strb_d;
   logic [CNT_W-1:0] ecc_corr_cnt_d, ecc_err_cnt_d;

   logic        word;
   logic        is_short;
   logic        hdr_bad;
   logic [15:0] in_wc;
   logic [16:0] p_calc;
   logic [16:0] cnt_inc;

   // eot_i wins over a same-cycle word, so a word only counts when eot_i is low
   assign word     = valid_i & ~eot_i;
   assign in_wc    = data_i[23:8];
   assign is_short = (data_i[5:0] <= SHORT_DT_MAX);
   assign hdr_bad  = (error_i & ~error_corrected_i) | (~is_short & (in_wc > MAX_WC));
   assign p_calc   = ({1'b0, in_wc} + 17'd3) >> 2;
   assign cnt_inc  = cnt_q + 17'd1;

   always_comb begin
      state_d        = state_q;
      wc_d           = wc_q;
      p_d            = p_q;
      cnt_d          = cnt_q;
      last_hi_d      = last_hi_q;
      pkt_done_d     = 1'b0;
      hdr_valid_d    = 1'b0;
      short_pkt_d    = short_pkt_o;
      hdr_vc_d       = hdr_vc_o;
      hdr_dt_d       = hdr_dt_o;
      hdr_wc_d       = hdr_wc_o;
      pl_valid_d     = 1'b0;
      pl_data_d      = pl_data_o;
      pl_strb_d      = pl_strb_o;
      pl_last_d      = 1'b0;
      crc_d          = crc_o;
      crc_valid_d    = 1'b0;
      wc_trunc_d     = 1'b0;
      ecc_corr_cnt_d = ecc_corr_cnt_o;
      ecc_err_cnt_d  = ecc_err_cnt_o;

      unique case (state_q)
         IDLE: begin
            if (word) begin
               if (hdr_bad) begin
                  if (ecc_err_cnt_o != '1) ecc_err_cnt_d = ecc_err_cnt_o + 1'b1;
                  state_d = DROP;
               end else begin
                  hdr_valid_d = 1'b1;
                  hdr_vc_d    = data_i[7:6];
                  hdr_dt_d    = data_i[5:0];
                  hdr_wc_d    = in_wc;
                  short_pkt_d = is_short;
                  if (error_corrected_i && ecc_corr_cnt_o != '1)
                     ecc_corr_cnt_d = ecc_corr_cnt_o + 1'b1;
                  wc_d  = in_wc;
                  p_d   = p_calc;
                  cnt_d = '0;
                  if (is_short)          state_d = DONE;
                  else if (p_calc != '0) state_d = PAYLOAD;
                  else                   state_d = CRC;
               end
            end
         end
         PAYLOAD: begin
            if (eot_i) begin
               wc_trunc_d = 1'b1;
               state_d    = DONE;
            end else if (valid_i) begin
               cnt_d      = cnt_inc;
               pl_valid_d = 1'b1;
               pl_data_d  = data_i;
               pl_strb_d  = 4'hF;
               last_hi_d  = data_i[31:24];
               if (cnt_inc == p_q) begin
                  pl_last_d = 1'b1;
                  // Tail bytes of the last word beyond WC already hold the CRC
                  unique case (wc_q[1:0])
                     2'd0: begin pl_strb_d = 4'hF; state_d = CRC; end
                     2'd1: begin
                        pl_strb_d   = 4'h1;
                        crc_d       = data_i[23:8];
                        crc_valid_d = 1'b1;
                        state_d     = DONE;
                     end
                     2'd2: begin
                        pl_strb_d   = 4'h3;
                        crc_d       = data_i[31:16];
                        crc_valid_d = 1'b1;
                        state_d     = DONE;
                     end
                     default: begin pl_strb_d = 4'h7; state_d = CRC; end
                  endcase
               end
            end
         end
         CRC: begin
            if (eot_i) begin
               wc_trunc_d = 1'b1;
               state_d    = DONE;
            end else if (valid_i) begin
               crc_d       = (wc_q[1:0] == 2'd0) ? data_i[15:0] : {data_i[7:0], last_hi_q};
               crc_valid_d = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            pkt_done_d = 1'b1;
            state_d    = IDLE;
         end
         DROP: begin
            if (eot_i) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   // All state and outputs are registered here so every output lags its causing word by one cycle
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q        <= IDLE;
         wc_q           <= '0;
         p_q            <= '0;
         cnt_q          <= '0;
         last_hi_q      <= '0;
         pkt_done_o     <= 1'b0;
         hdr_valid_o    <= 1'b0;
         hdr_vc_o       <= '0;
         hdr_dt_o       <= '0;
         hdr_wc_o       <= '0;
         short_pkt_o    <= 1'b0;
         pl_valid_o     <= 1'b0;
         pl_data_o      <= '0;
         pl_strb_o      <= '0;
         pl_last_o      <= 1'b0;
         crc_o          <= '0;
         crc_valid_o    <= 1'b0;
         wc_trunc_o     <= 1'b0;
         ecc_corr_cnt_o <= '0;
         ecc_err_cnt_o  <= '0;
      end else begin
         state_q        <= state_d;
         wc_q           <= wc_d;
         p_q            <= p_d;
         cnt_q          <= cnt_d;
         last_hi_q      <= last_hi_d;
         pkt_done_o     <= pkt_done_d;
         hdr_valid_o    <= hdr_valid_d;
         hdr_vc_o       <= hdr_vc_d;
         hdr_dt_o       <= hdr_dt_d;
         hdr_wc_o       <= hdr_wc_d;
         short_pkt_o    <= short_pkt_d;
         pl_valid_o     <= pl_valid_d;
         pl_data_o      <= pl_data_d;
         pl_strb_o      <= pl_strb_d;
         pl_last_o      <= pl_last_d;
         crc_o          <= crc_d;
         crc_valid_o    <= crc_valid_d;
         wc_trunc_o     <= wc_trunc_d;
         ecc_corr_cnt_o <= ecc_corr_cnt_d;
         ecc_err_cnt_o  <= ecc_err_cnt_d;
      end
   end

endmodule

// File: tb/tb_csi2_pkt_ctrl.sv
// Directed bench for csi2_pkt_ctrl: short/long packets, CRC extraction, bad headers and eot_i aborts.
module tb_csi2_pkt_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        valid_i;
   logic [31:0] data_i;
   logic        error_i;
   logic        error_corrected_i;
   logic        eot_i;
   logic        pkt_done_o;
   logic        hdr_valid_o;
   logic [1:0]  hdr_vc_o;
   logic [5:0]  hdr_dt_o;
   logic [15:0] hdr_wc_o;
   logic        short_pkt_o;
   logic        pl_valid_o;
   logic [31:0] pl_data_o;
   logic [3:0]  pl_strb_o;
   logic        pl_last_o;
   logic [15:0] crc_o;
   logic        crc_valid_o;
   logic        wc_trunc_o;
   logic [15:0] ecc_corr_cnt_o;
   logic [15:0] ecc_err_cnt_o;

   int testsRun = 0;
   int testsFailed = 0;

   csi2_pkt_ctrl dut (
      .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .data_i(data_i),
      .error_i(error_i), .error_corrected_i(error_corrected_i), .eot_i(eot_i),
      .pkt_done_o(pkt_done_o), .hdr_valid_o(hdr_valid_o), .hdr_vc_o(hdr_vc_o),
      .hdr_dt_o(hdr_dt_o), .hdr_wc_o(hdr_wc_o), .short_pkt_o(short_pkt_o),
      .pl_valid_o(pl_valid_o), .pl_data_o(pl_data_o), .pl_strb_o(pl_strb_o),
      .pl_last_o(pl_last_o), .crc_o(crc_o), .crc_valid_o(crc_valid_o),
      .wc_trunc_o(wc_trunc_o), .ecc_corr_cnt_o(ecc_corr_cnt_o), .ecc_err_cnt_o(ecc_err_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   // Drive one cycle of inputs, then sample the registered outputs 1 ns after the edge
   task automatic applyStimulus(input logic v, input logic [31:0] d, input logic e,
                                input logic c, input logic eot);
      @(negedge clk_i);
      valid_i           = v;
      data_i            = d;
      error_i           = e;
      error_corrected_i = c;
      eot_i             = eot;
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   initial begin
      rst_i = 1'b1;
      valid_i = 1'b0; data_i = '0; error_i = 1'b0; error_corrected_i = 1'b0; eot_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      checkOutput("rst_hdr_valid", {31'd0, hdr_valid_o}, 32'd0);
      checkOutput("rst_pkt_done", {31'd0, pkt_done_o}, 32'd0);
      checkOutput("rst_crc", {16'd0, crc_o}, 32'd0);
      checkOutput("rst_corr_cnt", {16'd0, ecc_corr_cnt_o}, 32'd0);
      checkOutput("rst_err_cnt", {16'd0, ecc_err_cnt_o}, 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;

      // Short frame-start packet
      applyStimulus(1'b1, {8'h00, 16'h0001, 2'b00, 6'h00}, 1'b0, 1'b0, 1'b0);
      checkOutput("short_hdr_valid", {31'd0, hdr_valid_o}, 32'd1);
      checkOutput("short_flag", {31'd0, short_pkt_o}, 32'd1);
      checkOutput("short_dt", {26'd0, hdr_dt_o}, 32'd0);
      checkOutput("short_wc", {16'd0, hdr_wc_o}, 32'd1);
      checkOutput("short_done_early", {31'd0, pkt_done_o}, 32'd0);
      idle();
      checkOutput("short_done", {31'd0, pkt_done_o}, 32'd1);
      checkOutput("short_hdr_pulse", {31'd0, hdr_valid_o}, 32'd0);
      idle();
      checkOutput("short_done_pulse", {31'd0, pkt_done_o}, 32'd0);

      // Long packet WC=6: second word carries 2 payload bytes then the CRC
      applyStimulus(1'b1, {8'h00, 16'd6, 2'b01, 6'h2A}, 1'b0, 1'b0, 1'b0);
      checkOutput("wc6_hdr_valid", {31'd0, hdr_valid_o}, 32'd1);
      checkOutput("wc6_short", {31'd0, short_pkt_o}, 32'd0);
      checkOutput("wc6_vc", {30'd0, hdr_vc_o}, 32'd1);
      checkOutput("wc6_dt", {26'd0, hdr_dt_o}, 32'h2A);
      applyStimulus(1'b1, 32'h44332211, 1'b0, 1'b0, 1'b0);
      checkOutput("wc6_w1_valid", {31'd0, pl_valid_o}, 32'd1);
      checkOutput("wc6_w1_data", pl_data_o, 32'h44332211);
      checkOutput("wc6_w1_strb", {28'd0, pl_strb_o}, 32'hF);
      checkOutput("wc6_w1_last", {31'd0, pl_last_o}, 32'd0);
      applyStimulus(1'b1, 32'hBEEF6655, 1'b0, 1'b0, 1'b0);
      checkOutput("wc6_w2_strb", {28'd0, pl_strb_o}, 32'h3);
      checkOutput("wc6_w2_last", {31'd0, pl_last_o}, 32'd1);
      checkOutput("wc6_crc_valid", {31'd0, crc_valid_o}, 32'd1);
      checkOutput("wc6_crc", {16'd0, crc_o}, 32'hBEEF);
      idle();
      checkOutput("wc6_done", {31'd0, pkt_done_o}, 32'd1);
      checkOutput("wc6_pl_idle", {31'd0, pl_valid_o}, 32'd0);

      // Long packet WC=4 with valid_i gaps; CRC arrives in its own word
      applyStimulus(1'b1, {8'h00, 16'd4, 2'b00, 6'h2B}, 1'b0, 1'b0, 1'b0);
      idle();
      applyStimulus(1'b1, 32'hA1A2A3A4, 1'b0, 1'b0, 1'b0);
      checkOutput("wc4_w1_strb", {28'd0, pl_strb_o}, 32'hF);
      checkOutput("wc4_w1_last", {31'd0, pl_last_o}, 32'd1);
      checkOutput("wc4_w1_nocrc", {31'd0, crc_valid_o}, 32'd0);
      idle();
      checkOutput("wc4_gap_pl", {31'd0, pl_valid_o}, 32'd0);
      applyStimulus(1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0);
      checkOutput("wc4_crc_pl", {31'd0, pl_valid_o}, 32'd0);
      checkOutput("wc4_crc_valid", {31'd0, crc_valid_o}, 32'd1);
      checkOutput("wc4_crc", {16'd0, crc_o}, 32'h5678);
      idle();
      checkOutput("wc4_done", {31'd0, pkt_done_o}, 32'd1);

      // WC=7: CRC straddles the last payload word and the CRC word
      applyStimulus(1'b1, {8'h00, 16'd7, 2'b00, 6'h2A}, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h11111111, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'hAB222222, 1'b0, 1'b0, 1'b0);
      checkOutput("wc7_strb", {28'd0, pl_strb_o}, 32'h7);
      checkOutput("wc7_last", {31'd0, pl_last_o}, 32'd1);
      applyStimulus(1'b1, 32'h000000CD, 1'b0, 1'b0, 1'b0);
      checkOutput("wc7_crc_valid", {31'd0, crc_valid_o}, 32'd1);
      checkOutput("wc7_crc", {16'd0, crc_o}, 32'hCDAB);
      idle();
      checkOutput("wc7_done", {31'd0, pkt_done_o}, 32'd1);

      // WC=0 long packet: no payload, CRC word only
      applyStimulus(1'b1, {8'h00, 16'd0, 2'b00, 6'h2C}, 1'b0, 1'b0, 1'b0);
      checkOutput("wc0_hdr_valid", {31'd0, hdr_valid_o}, 32'd1);
      applyStimulus(1'b1, 32'h0000BEAD, 1'b0, 1'b0, 1'b0);
      checkOutput("wc0_no_pl", {31'd0, pl_valid_o}, 32'd0);
      checkOutput("wc0_crc", {16'd0, crc_o}, 32'hBEAD);
      idle();
      checkOutput("wc0_done", {31'd0, pkt_done_o}, 32'd1);

      // Uncorrectable header: dropped until eot_i
      applyStimulus(1'b1, {8'h00, 16'd4, 2'b00, 6'h2A}, 1'b1, 1'b0, 1'b0);
      checkOutput("bad_hdr_valid", {31'd0, hdr_valid_o}, 32'd0);
      checkOutput("bad_err_cnt", {16'd0, ecc_err_cnt_o}, 32'd1);
      applyStimulus(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
      checkOutput("bad_drop_pl", {31'd0, pl_valid_o}, 32'd0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      idle();
      checkOutput("bad_eot_done", {31'd0, pkt_done_o}, 32'd1);

      // Corrected header behaves normally
      applyStimulus(1'b1, {8'h00, 16'h1234, 2'b10, 6'h01}, 1'b1, 1'b1, 1'b0);
      checkOutput("corr_hdr_valid", {31'd0, hdr_valid_o}, 32'd1);
      checkOutput("corr_wc", {16'd0, hdr_wc_o}, 32'h1234);
      checkOutput("corr_cnt", {16'd0, ecc_corr_cnt_o}, 32'd1);
      idle();
      checkOutput("corr_done", {31'd0, pkt_done_o}, 32'd1);

      // Oversize word count treated as a bad header
      applyStimulus(1'b1, {8'h00, 16'h2001, 2'b00, 6'h2A}, 1'b0, 1'b0, 1'b0);
      checkOutput("big_hdr_valid", {31'd0, hdr_valid_o}, 32'd0);
      checkOutput("big_err_cnt", {16'd0, ecc_err_cnt_o}, 32'd2);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      idle();
      checkOutput("big_eot_done", {31'd0, pkt_done_o}, 32'd1);

      // eot_i in IDLE is ignored
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      idle();
      checkOutput("idle_eot_nodone", {31'd0, pkt_done_o}, 32'd0);

      // Truncation: eot_i with payload word 2 of WC=100
      applyStimulus(1'b1, {8'h00, 16'd100, 2'b00, 6'h2A}, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h01020304, 1'b0, 1'b0, 1'b0);
      checkOutput("trunc_w1_valid", {31'd0, pl_valid_o}, 32'd1);
      applyStimulus(1'b1, 32'h05060708, 1'b0, 1'b0, 1'b1);
      checkOutput("trunc_pulse", {31'd0, wc_trunc_o}, 32'd1);
      checkOutput("trunc_w2_dropped", {31'd0, pl_valid_o}, 32'd0);
      checkOutput("trunc_no_last", {31'd0, pl_last_o}, 32'd0);
      idle();
      checkOutput("trunc_done", {31'd0, pkt_done_o}, 32'd1);
      checkOutput("trunc_no_crc", {31'd0, crc_valid_o}, 32'd0);
      applyStimulus(1'b1, {8'h00, 16'd5, 2'b11, 6'h02}, 1'b0, 1'b0, 1'b0);
      checkOutput("after_trunc_hdr", {31'd0, hdr_valid_o}, 32'd1);
      checkOutput("after_trunc_vc", {30'd0, hdr_vc_o}, 32'd3);
      idle();
      checkOutput("final_corr_cnt", {16'd0, ecc_corr_cnt_o}, 32'd1);
      checkOutput("final_err_cnt", {16'd0, ecc_err_cnt_o}, 32'd2);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
